vga_multitrace_renderer: RTL and testbench
==========================================

// Module: vga_multitrace_renderer
// PURPOSE
//  Parametrised multi-channel waveform renderer for the VGA path. Splits the 640x480 screen into
//  NUM_CH horizontal bands, fetches one sample per pixel from the shared signal RAM, and draws each
//  channel as a dot or connected trace in its own colour. Supports circular-buffer scrolling with a
//  per-frame freeze, and re-aligns sync with the pipelined RGB. Sits between VGATimingGenerator and the pins.
// PARAMETERS
//  NUM_CH    2              number of channels/bands (1..4)
//  SAMPLE_W  12             valid sample bits in sig_data[SAMPLE_W-1:0]
//  ADDR_W    12             RAM address width
//  BUF_DEPTH 640            samples per channel circular buffer (<= 640)
//  BAND_H    240            rows per band; NUM_CH*BAND_H <= 480
//  SHIFT     4              right shift applied to sample before plotting
//  BASE_ADDR {12'hC7F,12'h801}  NUM_CH*ADDR_W flattened; channel c base at [c*ADDR_W +: ADDR_W]
//  COLOR     {12'hFFF,12'h0F0}  NUM_CH*12 flattened {R,G,B} per channel, same packing
// PORTS
//  clock       in   1         system clock
//  reset       in   1         synchronous, active-high
//  pix_en      in   1         one-cycle pixel strobe (25 MHz rate); all state advances only when high
//  active_in   in   1         visible-area flag from timing generator
//  x           in   10        pixel column
//  y           in   9         pixel row
//  hsync_in    in   1         horizontal sync from timing generator
//  vsync_in    in   1         vertical sync from timing generator
//  frame_start in   1         one-pixel pulse at end of frame (screenEnd)
//  mode        in   1         0 = dot trace, 1 = connected trace
//  freeze      in   1         1 = keep current scroll position at next frame_start
//  scroll_ptr  in   ADDR_W    oldest-sample index of circular buffers (writer pointer)
//  sig_addr    out  ADDR_W    RAM read address (registered)
//  sig_data    in   32        RAM read data, valid before next pix_en after sig_addr changes
//  hsync_out   out  1         hsync_in delayed 2 pixels
//  vsync_out   out  1         vsync_in delayed 2 pixels
//  VGA_R/G/B   out  4 each    pixel colour
// BEHAVIOUR
//  Reset: sig_addr=0, VGA_R/G/B=0, hsync_out=vsync_out=1, shadow ptr=0, shadow mode=0, prev_trace=0,
//   pipeline valid bits=0. Reset mid-frame blanks output within 1 clock; rendering resumes on next pix_en.
//  Frame shadow: on pix_en&frame_start: shadow_mode<=mode; shadow_ptr<=freeze ? shadow_ptr :
//   (scroll_ptr>=BUF_DEPTH ? 0 : scroll_ptr). Mid-frame changes to mode/scroll_ptr/freeze have no effect.
//  S0 (pix_en k): ch=y/BAND_H, row=y-ch*BAND_H; idx=shadow_ptr+x, minus BUF_DEPTH if >=BUF_DEPTH (wrap);
//   sig_addr<=BASE_ADDR[ch]+idx (ADDR_W wrap). Pixel valid0 = active_in & ch<NUM_CH & x<BUF_DEPTH;
//   if not valid0, sig_addr holds. ch, row, x==0, valid0 piped forward.
//  S1 (pix_en k+1): s=sig_data[SAMPLE_W-1:0]>>SHIFT; trace=(s>BAND_H-1)?0:BAND_H-1-s (saturate).
//  S2 (pix_en k+2): dot: hit=(row==trace). connected: lo/hi=min/max(trace,prev_trace), hit=lo<=row<=hi;
//   when piped x==0, prev_trace treated as trace. prev_trace<=trace on every valid S1 pixel.
//   RGB<=hit ? COLOR[ch] : (row==BAND_H-1 ? 12'h444 divider : 0); invalid pixel -> 0.
//  Latency: x/y/active to RGB = 2 pix_en; hsync/vsync delayed identically, so alignment is exact.
//  pix_en low: every register holds; sig_addr must stay stable.
//  Rows y>=NUM_CH*BAND_H and columns x>=BUF_DEPTH are black, no RAM access.
// TESTING
//  reset mid-line, release -> RGB=0, syncs=1 during reset; first coloured pixel exactly 2 pix_en after release.
//  RAM model mem[addr]=addr; ptr=0, NUM_CH=2: at y=10,x=5 -> sig_addr=12'h806 next pix_en; y=250 -> 12'hC84.
//  ptr=600, x=50 -> idx wraps to 10, sig_addr=12'h80B; x=39 -> idx 639 (12'hA80).
//  samples 0 then 4095: trace rows 239 then 0 (saturated); mode=1 fills rows 0..239 at second column.
//  freeze=1 at frame_start while scroll_ptr changes -> next frame addresses identical to previous frame.
//  toggle mode mid-frame -> current frame unchanged, new mode from first pixel after next frame_start.

Source files
------------

// File: rtl/vga_multitrace_renderer.sv
// Multi-channel waveform renderer: maps each pixel to a channel band, fetches its sample from the
// shared signal RAM and draws a dot or connected trace, with sync delayed to match the RGB pipeline.
module vga_multitrace_renderer #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned SAMPLE_W  = 12,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BUF_DEPTH = 640,
    parameter int unsigned BAND_H    = 240,
    parameter int unsigned SHIFT     = 4,
    parameter logic [NUM_CH*ADDR_W-1:0] BASE_ADDR = {12'hC7F, 12'h801},
    parameter logic [NUM_CH*12-1:0]     COLOR     = {12'hFFF, 12'h0F0}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              active_in,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              frame_start,
    input  logic              mode,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] scroll_ptr,
    output logic [ADDR_W-1:0] sig_addr,
    input  logic [31:0]       sig_data,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B
);

    localparam int unsigned SUM_W = ((ADDR_W > 10) ? ADDR_W : 10) + 1;

    // Per-frame shadow copies of the scroll pointer and trace mode
    logic [ADDR_W-1:0] shadow_ptr_q;
    logic              shadow_mode_q;

    // Stage 1 (address issued, waiting for RAM data)
    logic       v1_q;
    logic [2:0] ch1_q;
    logic [8:0] row1_q;
    logic       xz1_q;
    logic       m1_q;

    // Stage 2 (trace row known)
    logic       v2_q;
    logic [2:0] ch2_q;
    logic [8:0] row2_q;
    logic       xz2_q;
    logic       m2_q;
    logic [8:0] trace2_q;
    logic [8:0] prev2_q;

    logic [8:0]  prev_trace_q;
    logic [11:0] rgb_q;
    logic [2:0]  hs_q;
    logic [2:0]  vs_q;
    logic [ADDR_W-1:0] addr_q;

    // ---------------------------------------------------------------- stage 0: address generation
    logic [2:0]        ch0;
    logic [8:0]        row0;
    logic              valid0;
    logic [SUM_W-1:0]  sum0;
    logic [SUM_W-1:0]  idx0;
    logic [ADDR_W-1:0] base0;
    logic [ADDR_W-1:0] addr0;

    always_comb begin
        ch0 = '0;
        for (int c = 1; c <= NUM_CH; c++) begin
            if (32'(y) >= 32'(c) * BAND_H) begin
                ch0 = 3'(c);
            end
        end
        row0 = y - 9'(32'(ch0) * BAND_H);

        sum0 = SUM_W'(shadow_ptr_q) + SUM_W'(x);
        idx0 = (sum0 >= SUM_W'(BUF_DEPTH)) ? (sum0 - SUM_W'(BUF_DEPTH)) : sum0;

        base0 = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch0 == 3'(c)) begin
                base0 = BASE_ADDR[c*ADDR_W +: ADDR_W];
            end
        end
        addr0 = base0 + idx0[ADDR_W-1:0];

        valid0 = active_in && (ch0 < 3'(NUM_CH)) && (32'(x) < BUF_DEPTH);
    end

    // ---------------------------------------------------------------- stage 1: sample to trace row
    logic [SAMPLE_W-1:0] s1;
    logic [8:0]          trace1;

    always_comb begin
        s1 = sig_data[SAMPLE_W-1:0] >> SHIFT;
        if (32'(s1) > BAND_H - 1) begin
            trace1 = '0;
        end else begin
            trace1 = 9'(BAND_H - 1) - 9'(s1);
        end
    end

    // ---------------------------------------------------------------- stage 2: hit test and colour
    logic [8:0]  prev_eff;
    logic [8:0]  lo2;
    logic [8:0]  hi2;
    logic        hit2;
    logic [11:0] col2;
    logic [11:0] rgb_d;

    always_comb begin
        // First column of a line has no left neighbour: treat it as a flat segment.
        prev_eff = xz2_q ? trace2_q : prev2_q;
        lo2      = (trace2_q < prev_eff) ? trace2_q : prev_eff;
        hi2      = (trace2_q < prev_eff) ? prev_eff : trace2_q;
        hit2     = m2_q ? ((row2_q >= lo2) && (row2_q <= hi2)) : (row2_q == trace2_q);

        col2 = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch2_q == 3'(c)) begin
                col2 = COLOR[c*12 +: 12];
            end
        end

        rgb_d = 12'h000;
        if (v2_q) begin
            if (hit2) begin
                rgb_d = col2;
            end else if (row2_q == 9'(BAND_H - 1)) begin
                rgb_d = 12'h444;
            end
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_ptr_q  <= '0;
            shadow_mode_q <= 1'b0;
            addr_q        <= '0;
            v1_q          <= 1'b0;
            ch1_q         <= '0;
            row1_q        <= '0;
            xz1_q         <= 1'b0;
            m1_q          <= 1'b0;
            v2_q          <= 1'b0;
            ch2_q         <= '0;
            row2_q        <= '0;
            xz2_q         <= 1'b0;
            m2_q          <= 1'b0;
            trace2_q      <= '0;
            prev2_q       <= '0;
            prev_trace_q  <= '0;
            rgb_q         <= '0;
            hs_q          <= '1;
            vs_q          <= '1;
        end else if (pix_en) begin
            if (frame_start) begin
                shadow_mode_q <= mode;
                if (!freeze) begin
                    shadow_ptr_q <= (32'(scroll_ptr) >= BUF_DEPTH) ? '0 : scroll_ptr;
                end
            end

            if (valid0) begin
                addr_q <= addr0;
            end
            v1_q   <= valid0;
            ch1_q  <= ch0;
            row1_q <= row0;
            xz1_q  <= (x == 10'd0);
            m1_q   <= shadow_mode_q;

            v2_q     <= v1_q;
            ch2_q    <= ch1_q;
            row2_q   <= row1_q;
            xz2_q    <= xz1_q;
            m2_q     <= m1_q;
            trace2_q <= trace1;
            prev2_q  <= prev_trace_q;
            if (v1_q) begin
                prev_trace_q <= trace1;
            end

            rgb_q <= rgb_d;
            hs_q  <= {hs_q[1:0], hsync_in};
            vs_q  <= {vs_q[1:0], vsync_in};
        end
    end

    assign sig_addr  = addr_q;
    assign hsync_out = hs_q[2];
    assign vsync_out = vs_q[2];
    assign VGA_R     = rgb_q[11:8];
    assign VGA_G     = rgb_q[7:4];
    assign VGA_B     = rgb_q[3:0];

    logic unused_data;
    assign unused_data = ^sig_data[31:SAMPLE_W];

endmodule

// File: tb/tb_vga_multitrace_renderer.sv
// Directed bench for vga_multitrace_renderer: addressing, scrolling/freeze, trace drawing, latency
// and reset behaviour against hand-computed values.
module tb_vga_multitrace_renderer;

    logic        clock = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        active_in;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        hsync_in;
    logic        vsync_in;
    logic        frame_start;
    logic        mode;
    logic        freeze;
    logic [11:0] scroll_ptr;
    logic [11:0] sig_addr;
    logic [31:0] sig_data;
    logic        hsync_out;
    logic        vsync_out;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic [11:0] rgb;
    logic        ram_ovr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vga_multitrace_renderer dut (
        .clock      (clock),
        .reset      (reset),
        .pix_en     (pix_en),
        .active_in  (active_in),
        .x          (x),
        .y          (y),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .frame_start(frame_start),
        .mode       (mode),
        .freeze     (freeze),
        .scroll_ptr (scroll_ptr),
        .sig_addr   (sig_addr),
        .sig_data   (sig_data),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B)
    );

    assign rgb = {VGA_R, VGA_G, VGA_B};

    // RAM model: mem[addr]=addr, or a two-value pattern (0 at 0x801, 4095 elsewhere) with junk high bits
    always_comb begin
        if (ram_ovr) begin
            sig_data = (sig_addr == 12'h801) ? 32'hFFFF_F000 : 32'hABCD_EFFF;
        end else begin
            sig_data = {20'h0, sig_addr};
        end
    end

    // One pixel strobe followed by an idle clock; returns at a falling edge
    task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic act,
                       input logic fs);
        @(negedge clock);
        x = px; y = py; active_in = act; frame_start = fs; pix_en = 1'b1;
        @(negedge clock);
        pix_en = 1'b0; frame_start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; pix_en = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        active_in = 1'b1; x = 10'd5; y = 9'd111;
        repeat (3) @(negedge clock);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb); end
        checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL reset_hs got %b exp 1", hsync_out); end
        checks++; if (vsync_out !== 1'b1) begin errors++; $display("FAIL reset_vs got %b exp 1", vsync_out); end
        checks++; if (sig_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h exp 000", sig_addr); end
        reset = 1'b0; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_latency();
        hsync_in = 1'b0; vsync_in = 1'b1;
        pix(10'd5, 9'd111, 1'b1, 1'b0);    // ch0: addr 806, sample 0x80 -> trace 111 -> hit
        checks++; if (sig_addr !== 12'h806) begin errors++; $display("FAIL lat_addr1 got %h exp 806", sig_addr); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL lat_rgb1 got %h exp 000", rgb); end
        hsync_in = 1'b1; vsync_in = 1'b0;
        pix(10'd6, 9'd279, 1'b1, 1'b0);    // ch1: addr C85, sample 0xC8 -> trace 39, row 39 -> hit
        checks++; if (sig_addr !== 12'hC85) begin errors++; $display("FAIL lat_addr2 got %h exp C85", sig_addr); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL lat_rgb2 got %h exp 000", rgb); end
        checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL lat_hs2 got %b exp 1", hsync_out); end
        vsync_in = 1'b1;
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'h0F0) begin errors++; $display("FAIL lat_rgb3 got %h exp 0F0", rgb); end
        checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL lat_hs3 got %b exp 0", hsync_out); end
        checks++; if (vsync_out !== 1'b1) begin errors++; $display("FAIL lat_vs3 got %b exp 1", vsync_out); end
        // pix_en low: inputs wiggle, nothing may move
        x = 10'd100; y = 9'd20; active_in = 1'b1; hsync_in = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (rgb !== 12'h0F0) begin errors++; $display("FAIL hold_rgb got %h exp 0F0", rgb); end
        checks++; if (sig_addr !== 12'hC85) begin errors++; $display("FAIL hold_addr got %h exp C85", sig_addr); end
        hsync_in = 1'b1;
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL lat_rgb4 got %h exp FFF", rgb); end
        checks++; if (vsync_out !== 1'b0) begin errors++; $display("FAIL lat_vs4 got %b exp 0", vsync_out); end
        checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL lat_hs4 got %b exp 1", hsync_out); end
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL lat_rgb5 got %h exp 000", rgb); end
    endtask

    task automatic test_boundaries();
        pix(10'd9, 9'd239, 1'b1, 1'b0);    // addr 80A, trace 111, last band row -> divider
        checks++; if (sig_addr !== 12'h80A) begin errors++; $display("FAIL bnd_addr got %h exp 80A", sig_addr); end
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'h444) begin errors++; $display("FAIL bnd_divider got %h exp 444", rgb); end
        pix(10'd5, 9'd480, 1'b1, 1'b0);    // below last band
        checks++; if (sig_addr !== 12'h80A) begin errors++; $display("FAIL bnd_row480 got %h exp 80A", sig_addr); end
        pix(10'd640, 9'd111, 1'b1, 1'b0);  // beyond buffer width
        checks++; if (sig_addr !== 12'h80A) begin errors++; $display("FAIL bnd_col640 got %h exp 80A", sig_addr); end
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL bnd_black got %h exp 000", rgb); end
        pix(10'd639, 9'd10, 1'b1, 1'b0);
        checks++; if (sig_addr !== 12'hA80) begin errors++; $display("FAIL bnd_col639 got %h exp A80", sig_addr); end
    endtask

    task automatic test_scroll();
        scroll_ptr = 12'd600; freeze = 1'b0;
        pix(10'd0, 9'd0, 1'b0, 1'b1);
        pix(10'd50, 9'd10, 1'b1, 1'b0);    // 650 wraps to 10
        checks++; if (sig_addr !== 12'h80B) begin errors++; $display("FAIL scr_wrap got %h exp 80B", sig_addr); end
        pix(10'd39, 9'd10, 1'b1, 1'b0);    // 639, no wrap
        checks++; if (sig_addr !== 12'hA80) begin errors++; $display("FAIL scr_639 got %h exp A80", sig_addr); end
        scroll_ptr = 12'd640;              // out of range -> 0
        pix(10'd0, 9'd0, 1'b0, 1'b1);
        pix(10'd5, 9'd10, 1'b1, 1'b0);
        checks++; if (sig_addr !== 12'h806) begin errors++; $display("FAIL scr_ptr640 got %h exp 806", sig_addr); end
        scroll_ptr = 12'd600;              // mid-frame change ignored
        pix(10'd5, 9'd10, 1'b1, 1'b0);
        checks++; if (sig_addr !== 12'h806) begin errors++; $display("FAIL scr_midframe got %h exp 806", sig_addr); end
    endtask

    task automatic test_freeze();
        scroll_ptr = 12'd600; freeze = 1'b0;
        pix(10'd0, 9'd0, 1'b0, 1'b1);
        pix(10'd50, 9'd10, 1'b1, 1'b0);
        checks++; if (sig_addr !== 12'h80B) begin errors++; $display("FAIL frz_pre got %h exp 80B", sig_addr); end
        scroll_ptr = 12'd100; freeze = 1'b1;
        pix(10'd0, 9'd0, 1'b0, 1'b1);
        pix(10'd50, 9'd10, 1'b1, 1'b0);
        checks++; if (sig_addr !== 12'h80B) begin errors++; $display("FAIL frz_hold got %h exp 80B", sig_addr); end
        pix(10'd39, 9'd10, 1'b1, 1'b0);
        checks++; if (sig_addr !== 12'hA80) begin errors++; $display("FAIL frz_hold39 got %h exp A80", sig_addr); end
        freeze = 1'b0;
        pix(10'd0, 9'd0, 1'b0, 1'b1);
        pix(10'd50, 9'd10, 1'b1, 1'b0);    // ptr 100: idx 150
        checks++; if (sig_addr !== 12'h897) begin errors++; $display("FAIL frz_release got %h exp 897", sig_addr); end
    endtask

    task automatic test_trace();
        logic [8:0]  rows [3];
        logic [11:0] exp_x0 [3];
        logic [11:0] exp_x1 [3];
        rows = '{9'd0, 9'd120, 9'd239};
        ram_ovr = 1'b1; scroll_ptr = 12'd0; freeze = 1'b0;
        for (int m = 1; m >= 0; m--) begin
            // x=0 sample 0 -> trace 239; x=1 sample 4095 -> saturates to trace 0
            if (m == 1) begin
                exp_x0 = '{12'h000, 12'h000, 12'h0F0};
                exp_x1 = '{12'h0F0, 12'h0F0, 12'h0F0};
            end else begin
                exp_x0 = '{12'h000, 12'h000, 12'h0F0};
                exp_x1 = '{12'h0F0, 12'h000, 12'h444};
            end
            mode = m[0];
            pix(10'd0, 9'd0, 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) begin
                pix(10'd0, rows[i], 1'b1, 1'b0);
                pix(10'd1, rows[i], 1'b1, 1'b0);
                pix(10'd7, 9'd0, 1'b0, 1'b0);
                checks++;
                if (rgb !== exp_x0[i]) begin
                    errors++;
                    $display("FAIL trace_m%0d_row%0d_x0 got %h exp %h", m, rows[i], rgb, exp_x0[i]);
                end
                pix(10'd7, 9'd0, 1'b0, 1'b0);
                checks++;
                if (rgb !== exp_x1[i]) begin
                    errors++;
                    $display("FAIL trace_m%0d_row%0d_x1 got %h exp %h", m, rows[i], rgb, exp_x1[i]);
                end
            end
        end
    endtask

    task automatic test_mode_midframe();
        // frame shadow currently holds dot mode
        mode = 1'b1;
        pix(10'd0, 9'd120, 1'b1, 1'b0);
        pix(10'd1, 9'd120, 1'b1, 1'b0);
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL mode_mid_dot got %h exp 000", rgb); end
        pix(10'd0, 9'd0, 1'b0, 1'b1);
        mode = 1'b0;                       // toggled back mid-frame, connected must persist
        pix(10'd0, 9'd120, 1'b1, 1'b0);
        pix(10'd1, 9'd120, 1'b1, 1'b0);
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'h0F0) begin errors++; $display("FAIL mode_next_conn got %h exp 0F0", rgb); end
        pix(10'd0, 9'd0, 1'b0, 1'b1);
        ram_ovr = 1'b0;
    endtask

    task automatic test_reset_midline();
        scroll_ptr = 12'd600; freeze = 1'b0; hsync_in = 1'b0;
        pix(10'd0, 9'd0, 1'b0, 1'b1);
        pix(10'd50, 9'd111, 1'b1, 1'b0);   // addr 80B, trace 111 -> hit
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        pix(10'd6, 9'd279, 1'b1, 1'b0);    // in flight at reset
        checks++; if (rgb !== 12'h0F0) begin errors++; $display("FAIL rstmid_pre got %h exp 0F0", rgb); end
        checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL rstmid_hs_pre got %b exp 0", hsync_out); end
        @(negedge clock);
        reset = 1'b1; pix_en = 1'b1;
        @(negedge clock);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL rstmid_rgb got %h exp 000", rgb); end
        checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL rstmid_hs got %b exp 1", hsync_out); end
        checks++; if (sig_addr !== 12'h000) begin errors++; $display("FAIL rstmid_addr got %h exp 000", sig_addr); end
        reset = 1'b0; pix_en = 1'b0; hsync_in = 1'b1;
        pix(10'd50, 9'd10, 1'b1, 1'b0);    // shadow ptr back to 0 -> addr 801+50
        checks++; if (sig_addr !== 12'h833) begin errors++; $display("FAIL rstmid_ptr got %h exp 833", sig_addr); end
        pix(10'd5, 9'd111, 1'b1, 1'b0);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL rstmid_flush got %h exp 000", rgb); end
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        pix(10'd7, 9'd0, 1'b0, 1'b0);
        checks++; if (rgb !== 12'h0F0) begin errors++; $display("FAIL rstmid_resume got %h exp 0F0", rgb); end
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; active_in = 1'b0; x = '0; y = '0;
        hsync_in = 1'b1; vsync_in = 1'b1; frame_start = 1'b0; mode = 1'b0; freeze = 1'b0;
        scroll_ptr = '0; ram_ovr = 1'b0;
        test_reset();
        test_latency();
        test_boundaries();
        test_scroll();
        test_freeze();
        test_trace();
        test_mode_midframe();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
